// File: rtl/afe_sample_sequencer.sv
//------------------------------------------------------------------------------
// afe_sample_sequencer
//
// Purpose:
//   Upstream feeder for the AFE threshold unit. Each AFE channel owns a
//   one-entry sample buffer. Pending buffers are served round-robin and
//   serialised onto one 32-bit tagged word bus. The valid output is a level
//   pulse with a programmable hold time and gap time. Both are long enough for
//   the consumer to pass valid through a 2-flop synchroniser and then detect
//   its rising edge.
//
// Ports:
//   clk_i           clock
//   rst_i           asynchronous, active-high reset
//   cfg_sel_i       config access select
//   cfg_wr_i        1 = write, 0 = read
//   cfg_addr_i      config register address (only [1:0] is decoded)
//   cfg_wdata_i     config write data
//   cfg_rdata_o     config read data (combinational)
//   smp_vld_i       per-channel single-cycle sample strobe
//   smp_subch_i     per-channel 2-bit subchannel ID
//   smp_data_i      per-channel sample data
//   afe_data_vld_o  level valid towards the threshold unit
//   afe_data_o      tagged sample word {ch, subch, data}
//   ovf_event_o     one-cycle pulse when any channel buffer is overwritten
//
// Register map (cfg_addr_i[1:0]):
//   0  en_mask[NUM_CH-1:0]           RW
//   1  ovf_status[NUM_CH-1:0]        RO, clear-on-read
//   2  hold[7:0], gap[15:8]          RW, values below 3 are stored as 3
//   3  reads 0, writes ignored
//------------------------------------------------------------------------------
module afe_sample_sequencer #(
   parameter int NUM_CH       = 8,
   parameter int W_AFE_DATA   = 16,
   parameter int W_CFG_ADDR   = 10,
   parameter int CH_ID_LSB    = 28,
   parameter int SUBCH_ID_LSB = 26
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         cfg_sel_i,
   input  logic                         cfg_wr_i,
   input  logic [W_CFG_ADDR-1:0]        cfg_addr_i,
   input  logic [31:0]                  cfg_wdata_i,
   output logic [31:0]                  cfg_rdata_o,
   input  logic [NUM_CH-1:0]            smp_vld_i,
   input  logic [NUM_CH*2-1:0]          smp_subch_i,
   input  logic [NUM_CH*W_AFE_DATA-1:0] smp_data_i,
   output logic                         afe_data_vld_o,
   output logic [31:0]                  afe_data_o,
   output logic                         ovf_event_o
);

   // Buffer entry layout: {subch[1:0], data[W_AFE_DATA-1:0]}
   localparam int W_ENT = W_AFE_DATA + 2;

   localparam logic [1:0] ADDR_EN_MASK = 2'd0;
   localparam logic [1:0] ADDR_OVF     = 2'd1;
   localparam logic [1:0] ADDR_TIMING  = 2'd2;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DRIVE = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;

   localparam logic [7:0] MIN_PHASE = 8'd3;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [NUM_CH-1:0] r_en_mask;
   logic [NUM_CH-1:0] r_ovf_status;
   logic [7:0]        r_hold;
   logic [7:0]        r_gap;
   logic [NUM_CH-1:0] r_pend;
   logic [W_ENT-1:0]  r_buf [NUM_CH];
   logic [3:0]        r_ptr;
   logic [1:0]        r_state;
   logic [7:0]        r_cnt;
   logic              r_vld;
   logic [31:0]       r_word;
   logic              r_ovf_evt;

   // ---------------------------------------------------------------------------
   // Config decode
   // ---------------------------------------------------------------------------
   logic              w_wr_en;
   logic              w_rd_en;
   logic [1:0]        w_reg;
   logic              w_wr_mask;
   logic              w_wr_timing;
   logic              w_rd_clr;
   logic [NUM_CH-1:0] w_mask_nxt;
   logic              w_unused;

   assign w_wr_en     = cfg_sel_i &  cfg_wr_i;
   assign w_rd_en     = cfg_sel_i & ~cfg_wr_i;
   assign w_reg       = cfg_addr_i[1:0];
   assign w_wr_mask   = w_wr_en && (w_reg == ADDR_EN_MASK);
   assign w_wr_timing = w_wr_en && (w_reg == ADDR_TIMING);
   assign w_rd_clr    = w_rd_en && (w_reg == ADDR_OVF);

   // The mask as it will be after this cycle; a channel being disabled right
   // now must lose its pending entry in the same cycle.
   assign w_mask_nxt = w_wr_mask ? cfg_wdata_i[NUM_CH-1:0] : r_en_mask;

   // Upper address bits and write-data bits beyond the widest field are
   // deliberately ignored.
   assign w_unused = ^{cfg_addr_i[W_CFG_ADDR-1:2], cfg_wdata_i[31:16]};

   function automatic logic [7:0] clamp_phase(input logic [7:0] v);
      return (v < MIN_PHASE) ? MIN_PHASE : v;
   endfunction

   // NOTE: every variable assigned in an always_comb gets a default first, so
   // no path can leave it holding its old value and infer a latch.
   always_comb begin
      cfg_rdata_o = '0;
      if (w_rd_en) begin
         case (w_reg)
            ADDR_EN_MASK: cfg_rdata_o[NUM_CH-1:0] = r_en_mask;
            ADDR_OVF:     cfg_rdata_o[NUM_CH-1:0] = r_ovf_status;
            ADDR_TIMING:  cfg_rdata_o[15:0]       = {r_gap, r_hold};
            default:      cfg_rdata_o             = '0;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Round-robin arbiter (IDLE only)
   // Rotate the pending vector so that bit 0 is the channel at ptr. The lowest
   // set bit of the rotated vector is then the winner's offset from ptr.
   // ---------------------------------------------------------------------------
   logic [2*NUM_CH-1:0] w_pend_dbl;
   logic [NUM_CH-1:0]   w_pend_rot;
   logic                w_rot_hit;
   logic [3:0]          w_rot_ofs;
   logic [4:0]          w_idx_sum;
   logic [3:0]          w_grant_idx;
   logic                w_grant_vld;
   logic [NUM_CH-1:0]   w_grant_oh;
   logic [3:0]          w_ptr_nxt;
   logic [W_ENT-1:0]    w_sel_ent;
   logic [31:0]         w_word;

   assign w_pend_dbl = {r_pend, r_pend} >> r_ptr;
   assign w_pend_rot = w_pend_dbl[NUM_CH-1:0];

   always_comb begin
      w_rot_hit = 1'b0;
      w_rot_ofs = '0;
      // Scanning downwards lets the lowest set bit win.
      for (int j = NUM_CH-1; j >= 0; j--) begin
         if (w_pend_rot[j]) begin
            w_rot_hit = 1'b1;
            w_rot_ofs = 4'(j);
         end
      end
   end

   assign w_idx_sum   = {1'b0, r_ptr} + {1'b0, w_rot_ofs};
   assign w_grant_idx = (w_idx_sum >= 5'(NUM_CH)) ? 4'(w_idx_sum - 5'(NUM_CH))
                                                  : w_idx_sum[3:0];
   assign w_grant_vld = (r_state == S_IDLE) && w_rot_hit;
   assign w_ptr_nxt   = (w_grant_idx == 4'(NUM_CH-1)) ? 4'd0 : w_grant_idx + 4'd1;

   always_comb begin
      w_grant_oh = '0;
      w_sel_ent  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_grant_oh[c] = w_grant_vld && (w_grant_idx == 4'(c));
         if (w_grant_oh[c]) begin
            w_sel_ent = r_buf[c];
         end
      end
   end

   always_comb begin
      w_word                        = '0;
      w_word[CH_ID_LSB +: 4]        = w_grant_idx;
      w_word[SUBCH_ID_LSB +: 2]     = w_sel_ent[W_AFE_DATA +: 2];
      w_word[W_AFE_DATA-1:0]        = w_sel_ent[W_AFE_DATA-1:0];
   end

   // ---------------------------------------------------------------------------
   // Capture and overflow
   // A granted channel has its old entry read out this cycle. A simultaneous
   // strobe on that channel therefore refills the buffer and is not an overflow.
   // ---------------------------------------------------------------------------
   logic [NUM_CH-1:0] w_cap;
   logic [NUM_CH-1:0] w_ovf;
   logic [NUM_CH-1:0] w_pend_nxt;

   assign w_cap      = smp_vld_i & r_en_mask;
   assign w_ovf      = w_cap & r_pend & ~w_grant_oh;
   assign w_pend_nxt = ((r_pend & ~w_grant_oh) | w_cap) & w_mask_nxt;

   // NOTE: the sample buffers have no reset; r_pend alone says whether an
   // entry is valid, so clearing r_pend empties every buffer.
   always_ff @(posedge clk_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (w_cap[c]) begin
            r_buf[c] <= {smp_subch_i[2*c +: 2], smp_data_i[W_AFE_DATA*c +: W_AFE_DATA]};
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values of the others no matter how the blocks are
   // ordered.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_en_mask    <= '1;
         r_ovf_status <= '0;
         r_hold       <= 8'd4;
         r_gap        <= 8'd4;
         r_pend       <= '0;
         r_ovf_evt    <= 1'b0;
      end else begin
         if (w_wr_mask) begin
            r_en_mask <= cfg_wdata_i[NUM_CH-1:0];
         end
         if (w_wr_timing) begin
            r_hold <= clamp_phase(cfg_wdata_i[7:0]);
            r_gap  <= clamp_phase(cfg_wdata_i[15:8]);
         end
         // If a read clears the status in the same cycle as a new overflow,
         // the read returns the old value and the new bit survives.
         r_ovf_status <= (w_rd_clr ? '0 : r_ovf_status) | w_ovf;
         r_pend       <= w_pend_nxt;
         r_ovf_evt    <= |w_ovf;
      end
   end

   // ---------------------------------------------------------------------------
   // Output sequencer
   // IDLE -> DRIVE for hold cycles -> GAP for gap cycles -> IDLE. The phase
   // counter is loaded from the timing register on phase entry. A timing write
   // therefore never stretches or cuts the phase that is already running.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_vld   <= 1'b0;
         r_word  <= '0;
         r_ptr   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_grant_vld) begin
                  r_state <= S_DRIVE;
                  r_cnt   <= r_hold;
                  r_vld   <= 1'b1;
                  r_word  <= w_word;
                  r_ptr   <= w_ptr_nxt;
               end
            end
            S_DRIVE: begin
               if (r_cnt == 8'd1) begin
                  r_state <= S_GAP;
                  r_cnt   <= r_gap;
                  r_vld   <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            S_GAP: begin
               if (r_cnt == 8'd1) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_vld   <= 1'b0;
            end
         endcase
      end
   end

   assign afe_data_vld_o = r_vld;
   assign afe_data_o     = r_word;
   assign ovf_event_o    = r_ovf_evt;

endmodule

// File: tb/tb_afe_sample_sequencer.sv
//------------------------------------------------------------------------------
// tb_afe_sample_sequencer
//
// Directed bench for afe_sample_sequencer. A timestamp-based model predicts
// valid, word and overflow event, and they are compared after every rising
// clock edge. Directed sections pin the model with hand-computed words,
// latencies, spacings and register read values.
//------------------------------------------------------------------------------
module tb_afe_sample_sequencer;

   localparam int NUM_CH = 8;
   localparam int W_D    = 16;
   localparam int W_A    = 10;

   logic                  clk_i = 1'b0;
   logic                  rst_i = 1'b1;
   logic                  cfg_sel_i = 1'b0;
   logic                  cfg_wr_i = 1'b0;
   logic [W_A-1:0]        cfg_addr_i = '0;
   logic [31:0]           cfg_wdata_i = '0;
   logic [31:0]           cfg_rdata_o;
   logic [NUM_CH-1:0]     smp_vld_i = '0;
   logic [NUM_CH*2-1:0]   smp_subch_i = '0;
   logic [NUM_CH*W_D-1:0] smp_data_i = '0;
   logic                  afe_data_vld_o;
   logic [31:0]           afe_data_o;
   logic                  ovf_event_o;

   afe_sample_sequencer #(
      .NUM_CH(NUM_CH), .W_AFE_DATA(W_D), .W_CFG_ADDR(W_A),
      .CH_ID_LSB(28), .SUBCH_ID_LSB(26)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cfg_sel_i(cfg_sel_i), .cfg_wr_i(cfg_wr_i), .cfg_addr_i(cfg_addr_i),
      .cfg_wdata_i(cfg_wdata_i), .cfg_rdata_o(cfg_rdata_o),
      .smp_vld_i(smp_vld_i), .smp_subch_i(smp_subch_i), .smp_data_i(smp_data_i),
      .afe_data_vld_o(afe_data_vld_o), .afe_data_o(afe_data_o),
      .ovf_event_o(ovf_event_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model. Time is counted in rising edges (cyc). A granted word
   // is valid for edges [drive_start, drive_end). The next grant may happen no
   // earlier than next_grant, which is fixed once the drive phase ends.
   // ---------------------------------------------------------------------------
   int                cyc = 0;
   logic [NUM_CH-1:0] m_pend;
   logic [NUM_CH-1:0] m_mask;
   logic [NUM_CH-1:0] m_ovf_st;
   logic [17:0]       m_buf [NUM_CH];
   int                m_ptr, m_hold, m_gap;
   int                m_drive_start, m_drive_end, m_next_grant;
   bit                m_in_word;
   logic [31:0]       m_word;
   bit                m_ovf_evt;

   logic [31:0] log_word[$];
   int          log_cyc[$];
   int          ovf_pulses = 0;
   logic        prev_vld = 1'b0;

   function automatic logic [31:0] word_of(input int ch, input logic [17:0] ent);
      logic [31:0] w;
      w        = '0;
      w[31:28] = ch[3:0];
      w[27:26] = ent[17:16];
      w[15:0]  = ent[15:0];
      return w;
   endfunction

   function automatic int clamp3(input logic [7:0] v);
      return (int'(v) < 3) ? 3 : int'(v);
   endfunction

   task automatic model_reset();
      m_pend = '0; m_mask = '1; m_ovf_st = '0;
      m_ptr = 0; m_hold = 4; m_gap = 4;
      m_drive_start = 0; m_drive_end = 0; m_next_grant = 0;
      m_in_word = 0; m_word = '0; m_ovf_evt = 0;
   endtask

   task automatic model_step(input int n);
      logic [NUM_CH-1:0] ovf;
      int g;
      ovf = '0;
      if (m_in_word && n == m_drive_end) begin
         m_next_grant = n + m_gap + 1;
         m_in_word    = 0;
      end
      if (!m_in_word && n >= m_next_grant && m_pend != '0) begin
         g = -1;
         for (int k = 0; k < NUM_CH; k++) begin
            if (g < 0 && m_pend[(m_ptr + k) % NUM_CH]) g = (m_ptr + k) % NUM_CH;
         end
         m_word        = word_of(g, m_buf[g]);
         m_pend[g]     = 1'b0;
         m_ptr         = (g + 1) % NUM_CH;
         m_drive_start = n;
         m_drive_end   = n + m_hold;
         m_in_word     = 1;
      end
      for (int c = 0; c < NUM_CH; c++) begin
         if (smp_vld_i[c] && m_mask[c]) begin
            if (m_pend[c]) ovf[c] = 1'b1;
            m_buf[c]  = {smp_subch_i[2*c +: 2], smp_data_i[W_D*c +: W_D]};
            m_pend[c] = 1'b1;
         end
      end
      if (cfg_sel_i && cfg_wr_i) begin
         if (cfg_addr_i[1:0] == 2'd0) m_mask = cfg_wdata_i[NUM_CH-1:0];
         if (cfg_addr_i[1:0] == 2'd2) begin
            m_hold = clamp3(cfg_wdata_i[7:0]);
            m_gap  = clamp3(cfg_wdata_i[15:8]);
         end
      end else if (cfg_sel_i && cfg_addr_i[1:0] == 2'd1) begin
         m_ovf_st = '0;
      end
      m_pend    = m_pend & m_mask;
      m_ovf_st  = m_ovf_st | ovf;
      m_ovf_evt = |ovf;
   endtask

   // Compare process: model update on each rising edge, DUT check 1 ns later.
   initial begin
      model_reset();
      forever begin
         @(posedge clk_i);
         cyc++;
         if (rst_i) begin
            model_reset();
            prev_vld = 1'b0;
         end else begin
            model_step(cyc);
         end
         #1;
         check("cyc_vld", {31'b0, afe_data_vld_o},
               {31'b0, (cyc >= m_drive_start && cyc < m_drive_end) ? 1'b1 : 1'b0});
         check("cyc_word", afe_data_o, m_word);
         check("cyc_ovf_evt", {31'b0, ovf_event_o}, {31'b0, m_ovf_evt});
         if (afe_data_vld_o && !prev_vld) begin
            log_word.push_back(afe_data_o);
            log_cyc.push_back(cyc);
         end
         prev_vld = afe_data_vld_o;
         if (ovf_event_o) ovf_pulses++;
      end
   end

   // ---------------------------------------------------------------------------
   // Driver helpers (called on falling edges)
   // ---------------------------------------------------------------------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      tick(2);
      rst_i = 1'b0;
      tick(1);
   endtask

   task automatic set_smp(input int ch, input logic [1:0] sub, input logic [15:0] d);
      smp_vld_i[ch]            = 1'b1;
      smp_subch_i[ch*2 +: 2]   = sub;
      smp_data_i[ch*W_D +: W_D] = d;
   endtask

   task automatic pulse();
      tick(1);
      smp_vld_i = '0;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
      cfg_sel_i = 1'b1; cfg_wr_i = 1'b1;
      cfg_addr_i = {8'b0, a}; cfg_wdata_i = d;
      tick(1);
      cfg_sel_i = 1'b0; cfg_wr_i = 1'b0;
   endtask

   task automatic cfg_read(input logic [1:0] a, input logic [31:0] exp, input string name);
      cfg_sel_i = 1'b1; cfg_wr_i = 1'b0;
      cfg_addr_i = {8'b0, a};
      #1;
      check(name, cfg_rdata_o, exp);
      tick(1);
      cfg_sel_i = 1'b0;
   endtask

   task automatic wait_words(input int n, input int budget, input string name);
      int k;
      k = 0;
      while (log_word.size() < n && k < budget) begin
         tick(1);
         k++;
      end
      check(name, 32'(log_word.size()), 32'(n));
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      int base, k0;
      logic [9:0] pat;
      logic [6:0] pat7;
      bit stable;

      tick(3);
      rst_i = 1'b0;
      tick(1);

      // Reset values
      check("reset_vld", {31'b0, afe_data_vld_o}, 32'd0);
      cfg_read(2'd0, 32'h0000_00FF, "reset_en_mask");
      cfg_read(2'd2, 32'h0000_0404, "reset_hold_gap");
      cfg_read(2'd1, 32'h0000_0000, "reset_ovf_status");
      cfg_read(2'd3, 32'h0000_0000, "unmapped_read");

      // Single sample: ch 3, subch 1, data 0x8001
      base = log_word.size();
      k0   = cyc;
      set_smp(3, 2'd1, 16'h8001);
      pulse();
      pat    = '0;
      stable = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         pat[i] = afe_data_vld_o;
         if (i < 8 && afe_data_o !== 32'h3400_8001) stable = 1'b0;
      end
      check("single_vld_pattern", {22'b0, pat}, 32'h0000_000F);
      check("single_word_stable", {31'b0, stable}, 32'd1);
      wait_words(base + 1, 20, "single_word_seen");
      check("single_word", log_word[base], 32'h3400_8001);
      check("single_latency", 32'(log_cyc[base] - k0), 32'd2);

      // Round-robin from ptr = 0
      do_reset();
      base = log_word.size();
      set_smp(0, 2'd0, 16'h1111);
      set_smp(2, 2'd2, 16'h2222);
      set_smp(7, 2'd3, 16'h7777);
      pulse();
      wait_words(base + 3, 60, "rr_words_seen");
      check("rr_word0", log_word[base],     32'h0000_1111);
      check("rr_word1", log_word[base + 1], 32'h2800_2222);
      check("rr_word2", log_word[base + 2], 32'h7C00_7777);
      check("rr_spacing01", 32'(log_cyc[base + 1] - log_cyc[base]),     32'd9);
      check("rr_spacing12", 32'(log_cyc[base + 2] - log_cyc[base + 1]), 32'd9);
      tick(10);
      base = log_word.size();
      set_smp(7, 2'd0, 16'h0707);
      set_smp(0, 2'd1, 16'hA0A0);
      pulse();
      wait_words(base + 2, 40, "rr_wrap_seen");
      check("rr_wrap_first",  log_word[base],     32'h0400_A0A0);
      check("rr_wrap_second", log_word[base + 1], 32'h7000_0707);
      tick(10);

      // Overflow on ch 5 while ch 1 is driving
      ovf_pulses = 0;
      base = log_word.size();
      set_smp(1, 2'd0, 16'h0101);
      pulse();
      tick(1);
      check("ovf_ch1_driving", {31'b0, afe_data_vld_o}, 32'd1);
      set_smp(5, 2'd0, 16'h5555);
      pulse();
      set_smp(5, 2'd1, 16'h5AAA);
      pulse();
      cfg_read(2'd1, 32'h0000_0020, "ovf_status_set");
      cfg_read(2'd1, 32'h0000_0000, "ovf_status_cleared");
      wait_words(base + 2, 40, "ovf_words_seen");
      check("ovf_ch1_word", log_word[base],     32'h1000_0101);
      check("ovf_ch5_word", log_word[base + 1], 32'h5400_5AAA);
      check("ovf_event_count", 32'(ovf_pulses), 32'd1);
      tick(10);

      // Timing config: hold/gap below 3 are stored as 3
      cfg_write(2'd2, 32'h0000_0102);
      cfg_read(2'd2, 32'h0000_0303, "hold_gap_clamped");
      base = log_word.size();
      set_smp(2, 2'd0, 16'h0002);
      set_smp(6, 2'd0, 16'h0006);
      pulse();
      wait_words(base + 2, 40, "cfg_words_seen");
      check("cfg_word_ch6", log_word[base],     32'h6000_0006);
      check("cfg_word_ch2", log_word[base + 1], 32'h2000_0002);
      check("cfg_period", 32'(log_cyc[base + 1] - log_cyc[base]), 32'd7);
      pat7 = '0;
      for (int i = 0; i < 7; i++) begin
         tick(1);
         pat7[i] = afe_data_vld_o;
      end
      check("cfg_vld_pattern", {25'b0, pat7}, 32'h0000_0003);

      // Disable ch 4 while it is pending; its later strobes are dropped
      base = log_word.size();
      set_smp(1, 2'd0, 16'h0011);
      pulse();
      tick(1);
      check("mask_ch1_driving", {31'b0, afe_data_vld_o}, 32'd1);
      set_smp(4, 2'd0, 16'h0044);
      pulse();
      cfg_write(2'd0, 32'h0000_0001);
      cfg_read(2'd0, 32'h0000_0001, "en_mask_readback");
      set_smp(4, 2'd0, 16'h0045);
      set_smp(0, 2'd3, 16'h00F0);
      pulse();
      tick(40);
      check("mask_word_count", 32'(log_word.size() - base), 32'd2);
      check("mask_word_ch1", log_word[base],     32'h1000_0011);
      check("mask_word_ch0", log_word[base + 1], 32'h0C00_00F0);
      cfg_write(2'd0, 32'h0000_00FF);

      // Reset in the middle of a drive phase, with ch 3 pending and overflowed
      set_smp(2, 2'd0, 16'h0022);
      pulse();
      tick(1);
      set_smp(3, 2'd0, 16'h0033);
      pulse();
      set_smp(3, 2'd1, 16'h0034);
      pulse();
      check("rst_pre_vld", {31'b0, afe_data_vld_o}, 32'd1);
      #2;
      rst_i = 1'b1;
      #1;
      check("rst_async_vld", {31'b0, afe_data_vld_o}, 32'd0);
      check("rst_async_word", afe_data_o, 32'h0000_0000);
      tick(2);
      rst_i = 1'b0;
      tick(1);
      base = log_word.size();
      cfg_read(2'd1, 32'h0000_0000, "rst_ovf_status");
      cfg_read(2'd2, 32'h0000_0404, "rst_hold_gap");
      tick(30);
      check("rst_no_stale_words", 32'(log_word.size() - base), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule
